fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage sequencer that owns the program counter, drives a single-outstanding req/ack instruction-memory port, and generates the write/flush controls and instruction/PC data for the IF/ID pipeline register. Detects load-use hazards against the ID/EX stage, buffers an instruction that returns during a stall, and discards stale responses after a branch/jump redirect. Sits between instruction memory, the IF/ID register and the EX-stage branch resolution logic.

## Interface
- PC_WIDTH, 32, program-counter / address width
- INST_WIDTH, 32, instruction width
- REG_ADDR_WIDTH, 5, register index width
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request; address must stay stable until imem_ack
- imem_addr  output  PC_WIDTH  fetch address
- imem_ack  input  1  response valid this cycle; qualifies imem_rdata
- imem_rdata  input  INST_WIDTH  fetched instruction
- redirect  input  1  branch taken / jump resolved this cycle
- redirect_pc  input  PC_WIDTH  redirect target; bits [1:0] ignored (forced 0)
- ID_EX_mem_read  input  1  instruction in ID/EX is a load
- ID_EX_rd  input  REG_ADDR_WIDTH  load destination
- IF_ID_rs1, IF_ID_rs2  input  REG_ADDR_WIDTH  sources of instruction in IF/ID
- inst  output  INST_WIDTH  instruction to IF/ID
- pc  output  PC_WIDTH  address of instruction presented on inst
- pc_next  output  PC_WIDTH  pc + 4
- IF_ID_write  output  1  IF/ID load enable
- IF_flush  output  1  IF/ID flush
- ID_EX_bubble  output  1  zero ID/EX control (insert bubble)
- perf_stall_cnt  output  32  load-use stall cycles
- perf_flush_cnt  output  32  redirect count

## Operation
- stall = ID_EX_mem_read & (ID_EX_rd != 0) & (ID_EX_rd == IF_ID_rs1 | ID_EX_rd == IF_ID_rs2); combinational. ID_EX_bubble = stall & ~redirect.
- IF_flush = redirect (combinational). Redirect has priority over stall and over any accept.
- Registers: pc, state, inst_buf. imem_addr = pc in FETCH/HOLD; in DRAIN, imem_addr = drain_addr (latched address of the abandoned request).
- inst = inst_buf in HOLD, else imem_rdata. pc_next = pc + 4 modulo 2^PC_WIDTH.
- States:
  - FETCH: imem_req = 1. redirect: pc <= redirect_pc; if imem_ack, drop the response and stay in FETCH; else drain_addr <= pc and go to DRAIN. Else imem_ack & ~stall: IF_ID_write = 1, pc <= pc + 4. Else imem_ack & stall: inst_buf <= imem_rdata, go to HOLD. No ack: hold.
  - HOLD: imem_req = 0. redirect: drop inst_buf, pc <= redirect_pc, go to FETCH. ~stall: IF_ID_write = 1 (inst_buf), pc <= pc + 4, go to FETCH. Else stay.
  - DRAIN: imem_req = 1 at drain_addr. IF_ID_write = 0. redirect: pc <= redirect_pc (stay). imem_ack: discard, go to FETCH.
- IF_ID_write is never asserted in the same cycle as IF_flush.

## Timing
- Reset: pc = RESET_PC, state = FETCH, inst_buf = 0, counters = 0. While reset is asserted: imem_req = 0, IF_ID_write = 0, IF_flush = 0, ID_EX_bubble = 0. imem_req rises the first cycle after reset deassertion.
- Zero-wait memory (ack in the same cycle as req): 1 instruction/cycle. IF/ID captures at the edge ending the ack cycle.
- Redirect at cycle N: IF_flush high in N; imem_addr = redirect_pc in N+1 (FETCH path) or after the stale ack (DRAIN path).
- HOLD release: IF_ID_write is asserted in the first cycle stall is low; no refetch.
- Reset mid-DRAIN or mid-HOLD: state returns to FETCH immediately; the memory must tolerate the abandoned request.

## Configuration
- FETCH_PERF_CNT_EN defined: perf_stall_cnt increments on every cycle ID_EX_bubble = 1; perf_flush_cnt increments on every cycle IF_flush = 1. Both are 32-bit wrapping counters, cleared by reset.
- Undefined: both outputs are tied to 0 and no counter flops exist.

## Test plan
- Reset with RESET_PC = 0x100, zero-wait memory -> imem_addr sequence 0x100, 0x104, 0x108; IF_ID_write high every cycle; pc_next = pc + 4.
- ID_EX_mem_read = 1, ID_EX_rd = 5, IF_ID_rs2 = 5 for 2 cycles while ack returns the instruction at 0x108 -> state HOLD, ID_EX_bubble high for 2 cycles, then IF_ID_write with the buffered instruction and pc = 0x108; no second fetch of 0x108; with FETCH_PERF_CNT_EN, perf_stall_cnt = 2.
- ID_EX_rd = 0 matching rs1 = 0 with mem_read = 1 -> no stall.
- 3-cycle-latency memory, redirect to 0x200 one cycle after the request to 0x10C -> IF_flush one cycle, DRAIN holds imem_addr = 0x10C until ack, stale data not written, next request at 0x200.
- redirect and stall both high in HOLD -> IF_flush = 1, ID_EX_bubble = 0, buffer dropped, next imem_addr = redirect_pc.
- redirect_pc = 0x203 -> fetch at 0x200; pc = 0xFFFFFFFC accepted -> pc wraps to 0x0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch-stage sequencer. Owns the program counter and drives a single
// outstanding req/ack port to instruction memory. Produces the IF/ID load
// enable and flush, inserts ID/EX bubbles on load-use hazards, buffers an
// instruction that returns while the pipeline is stalled, and discards the
// stale response of a request abandoned by a branch/jump redirect.
//
// Parameters:
//   PC_WIDTH        program-counter / address width
//   INST_WIDTH      instruction width
//   REG_ADDR_WIDTH  register index width
//   RESET_PC        PC value loaded on reset
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   imem_req/imem_addr          fetch request and address (address stable
//                               until imem_ack)
//   imem_ack/imem_rdata         memory response and fetched instruction
//   redirect/redirect_pc        taken branch / resolved jump and its target
//   ID_EX_mem_read, ID_EX_rd    load in ID/EX and its destination
//   IF_ID_rs1, IF_ID_rs2        sources of the instruction held in IF/ID
//   inst, pc, pc_next           instruction, its address, and address + 4
//   IF_ID_write, IF_flush       IF/ID load enable and flush
//   ID_EX_bubble                zero the ID/EX control word
//   perf_stall_cnt              load-use stall cycles
//   perf_flush_cnt              redirect cycles
//
// Build option:
//   FETCH_PERF_CNT_EN  when defined, the two perf outputs are live 32-bit
//                      wrapping counters; otherwise they are tied to zero.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int                  PC_WIDTH       = 32,
    parameter int                  INST_WIDTH     = 32,
    parameter int                  REG_ADDR_WIDTH = 5,
    parameter logic [PC_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req,
    output logic [PC_WIDTH-1:0]       imem_addr,
    input  logic                      imem_ack,
    input  logic [INST_WIDTH-1:0]     imem_rdata,
    input  logic                      redirect,
    input  logic [PC_WIDTH-1:0]       redirect_pc,
    input  logic                      ID_EX_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    output logic [INST_WIDTH-1:0]     inst,
    output logic [PC_WIDTH-1:0]       pc,
    output logic [PC_WIDTH-1:0]       pc_next,
    output logic                      IF_ID_write,
    output logic                      IF_flush,
    output logic                      ID_EX_bubble,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_flush_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    state_t                  state, state_d;
    logic [PC_WIDTH-1:0]     pc_d;
    logic [PC_WIDTH-1:0]     drain_addr, drain_addr_d;
    logic [INST_WIDTH-1:0]   inst_buf, inst_buf_d;
    logic [PC_WIDTH-1:0]     redirect_target;
    logic                    stall;

    // Load-use hazard: a load to a non-zero register that the instruction in
    // IF/ID reads. x0 is hardwired, so a "load to x0" never creates a hazard.
    assign stall = ID_EX_mem_read && (ID_EX_rd != '0) &&
                   ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

    // Targets are word aligned; the low two bits of the target are ignored.
    assign redirect_target = redirect_pc & ALIGN_MASK;

    // A redirect always wins, so the bubble is suppressed when the flush
    // already kills the instruction in IF/ID.
    assign IF_flush     = redirect && !reset;
    assign ID_EX_bubble = stall && !redirect && !reset;

    assign pc_next   = pc + PC_STEP;
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;
    assign inst      = (state == HOLD) ? inst_buf : imem_rdata;

    // State register plus PC, stall buffer and abandoned-request address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            inst_buf   <= '0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            drain_addr <= drain_addr_d;
            inst_buf   <= inst_buf_d;
        end
    end

    // Next-state and handshake outputs. In FETCH a redirect that coincides
    // with the ack simply drops that response; without the ack the request
    // is still in flight and must be drained before the new target is sent.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        drain_addr_d = drain_addr;
        inst_buf_d   = inst_buf;
        imem_req     = 1'b0;
        IF_ID_write  = 1'b0;

        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_d = redirect_target;
                    if (!imem_ack) begin
                        drain_addr_d = pc;
                        state_d      = DRAIN;
                    end
                end else if (imem_ack && !stall) begin
                    IF_ID_write = 1'b1;
                    pc_d        = pc_next;
                end else if (imem_ack) begin
                    inst_buf_d = imem_rdata;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = FETCH;
                end else if (!stall) begin
                    IF_ID_write = 1'b1;
                    pc_d        = pc_next;
                    state_d     = FETCH;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_d = redirect_target;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (reset) begin
            imem_req    = 1'b0;
            IF_ID_write = 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Event counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ID_EX_bubble) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (IF_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl. A small instruction memory with selectable
// latency answers requests; a behavioural model tracks the architectural
// view (PC, buffered instruction, abandoned request) and is compared with the
// DUT every cycle, while the directed sequence pins key cycles with
// hand-computed literals.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ID_EX_mem_read;
    logic [4:0]  ID_EX_rd;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        IF_ID_write;
    logic        IF_flush;
    logic        ID_EX_bubble;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    fetch_ctrl #(
        .PC_WIDTH       (32),
        .INST_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .RESET_PC       (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .ID_EX_mem_read (ID_EX_mem_read),
        .ID_EX_rd       (ID_EX_rd),
        .IF_ID_rs1      (IF_ID_rs1),
        .IF_ID_rs2      (IF_ID_rs2),
        .inst           (inst),
        .pc             (pc),
        .pc_next        (pc_next),
        .IF_ID_write    (IF_ID_write),
        .IF_flush       (IF_flush),
        .ID_EX_bubble   (ID_EX_bubble),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory content is a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory with `latency` wait cycles before the ack cycle (0 = zero-wait).
    int latency;
    int wait_cnt;

    always_comb begin
        imem_ack   = imem_req && (wait_cnt >= latency);
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 0;
        end else if (imem_req && !imem_ack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic redir,
                                 input logic [31:0] rpc, input logic mr,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2);
        reset          = rst;
        redirect       = redir;
        redirect_pc    = rpc;
        ID_EX_mem_read = mr;
        ID_EX_rd       = rd;
        IF_ID_rs1      = rs1;
        IF_ID_rs2      = rs2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: the PC of the next instruction to deliver, an
    // optional instruction waiting for the stall to clear, and an optional
    // abandoned request whose response must be thrown away.
    logic [31:0] m_pc;
    logic        m_buf_valid;
    logic [31:0] m_buf;
    logic        m_stale;
    logic [31:0] m_stale_addr;
    int          m_stall_cnt;
    int          m_flush_cnt;
    logic        prev_pending;
    logic [31:0] prev_addr;

    always @(negedge clk) begin : model_check
        logic        stall_e;
        logic        write_e;
        logic [31:0] addr_e;
        logic [31:0] inst_e;
        logic [31:0] tgt;

        if (reset) begin
            checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
            checkOutput("rst_if_id_write", {31'd0, IF_ID_write}, 32'd0);
            checkOutput("rst_if_flush", {31'd0, IF_flush}, 32'd0);
            checkOutput("rst_bubble", {31'd0, ID_EX_bubble}, 32'd0);
            checkOutput("rst_pc", pc, RESET_PC);
            checkOutput("rst_stall_cnt", perf_stall_cnt, 32'd0);
            checkOutput("rst_flush_cnt", perf_flush_cnt, 32'd0);
            m_pc         = RESET_PC;
            m_buf_valid  = 1'b0;
            m_buf        = 32'd0;
            m_stale      = 1'b0;
            m_stale_addr = 32'd0;
            m_stall_cnt  = 0;
            m_flush_cnt  = 0;
            prev_pending = 1'b0;
            prev_addr    = 32'd0;
        end else begin
            stall_e = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
                      ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));
            addr_e  = m_stale ? m_stale_addr : m_pc;
            inst_e  = m_buf_valid ? m_buf : imem_rdata;
            write_e = !redirect && !stall_e &&
                      (m_buf_valid || (!m_stale && imem_ack));
            tgt     = {redirect_pc[31:2], 2'b00};

            checkOutput("imem_req", {31'd0, imem_req}, {31'd0, !m_buf_valid});
            if (!m_buf_valid) begin
                checkOutput("imem_addr", imem_addr, addr_e);
            end
            checkOutput("pc", pc, m_pc);
            checkOutput("pc_next", pc_next, m_pc + 32'd4);
            checkOutput("if_id_write", {31'd0, IF_ID_write}, {31'd0, write_e});
            checkOutput("if_flush", {31'd0, IF_flush}, {31'd0, redirect});
            checkOutput("bubble", {31'd0, ID_EX_bubble},
                        {31'd0, stall_e && !redirect});
            if (write_e) begin
                checkOutput("inst", inst, inst_e);
            end
            checkOutput("perf_stall_cnt", perf_stall_cnt,
                        PERF_EN ? 32'(m_stall_cnt) : 32'd0);
            checkOutput("perf_flush_cnt", perf_flush_cnt,
                        PERF_EN ? 32'(m_flush_cnt) : 32'd0);
            if (prev_pending) begin
                checkOutput("addr_stable", imem_addr, prev_addr);
            end

            prev_pending = imem_req && !imem_ack;
            prev_addr    = imem_addr;
            if (stall_e && !redirect) m_stall_cnt++;
            if (redirect) m_flush_cnt++;

            if (redirect) begin
                if (m_buf_valid) begin
                    m_buf_valid = 1'b0;
                end else if (m_stale) begin
                    if (imem_ack) m_stale = 1'b0;
                end else if (!imem_ack) begin
                    m_stale      = 1'b1;
                    m_stale_addr = m_pc;
                end
                m_pc = tgt;
            end else if (m_stale) begin
                if (imem_ack) m_stale = 1'b0;
            end else if (m_buf_valid) begin
                if (!stall_e) begin
                    m_buf_valid = 1'b0;
                    m_pc        = m_pc + 32'd4;
                end
            end else if (imem_ack) begin
                if (stall_e) begin
                    m_buf_valid = 1'b1;
                    m_buf       = imem_rdata;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Directed sequence with literal expectations at key cycles.
    initial begin
        latency = 0;
        // Reset with redirect and a hazard present: all controls stay low.
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 5'd3, 5'd3, 5'd0);
        @(negedge clk);
        checkOutput("lit_reset_req", {31'd0, imem_req}, 32'd0);
        checkOutput("lit_reset_flush", {31'd0, IF_flush}, 32'd0);
        checkOutput("lit_reset_bubble", {31'd0, ID_EX_bubble}, 32'd0);

        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("lit_addr_100", imem_addr, 32'h100);
        checkOutput("lit_write_100", {31'd0, IF_ID_write}, 32'd1);
        checkOutput("lit_pc_next_104", pc_next, 32'h104);

        // Load to x0 matching rs1 = x0 is not a hazard.
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("lit_addr_104", imem_addr, 32'h104);
        checkOutput("lit_x0_no_bubble", {31'd0, ID_EX_bubble}, 32'd0);
        checkOutput("lit_x0_write", {31'd0, IF_ID_write}, 32'd1);

        // Load-use stall for two cycles while 0x108 returns.
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 5'd5, 5'd1, 5'd5);
        @(negedge clk);
        checkOutput("lit_addr_108", imem_addr, 32'h108);
        checkOutput("lit_stall1_bubble", {31'd0, ID_EX_bubble}, 32'd1);
        checkOutput("lit_stall1_write", {31'd0, IF_ID_write}, 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("lit_hold_req", {31'd0, imem_req}, 32'd0);
        checkOutput("lit_stall2_bubble", {31'd0, ID_EX_bubble}, 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("lit_release_write", {31'd0, IF_ID_write}, 32'd1);
        checkOutput("lit_release_pc", pc, 32'h108);
        checkOutput("lit_release_inst", inst, 32'hA5A5_0108);
        checkOutput("lit_release_no_refetch", {31'd0, imem_req}, 32'd0);
        checkOutput("lit_stall_cnt_2", perf_stall_cnt, PERF_EN ? 32'd2 : 32'd0);

        // Slow memory; redirect one cycle after the request to 0x10C.
        nextCycle();
        latency = 3;
        @(negedge clk);
        checkOutput("lit_addr_10c", imem_addr, 32'h10C);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("lit_redirect_flush", {31'd0, IF_flush}, 32'd1);
        checkOutput("lit_redirect_write", {31'd0, IF_ID_write}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("lit_drain_addr", imem_addr, 32'h10C);
        checkOutput("lit_drain_flush_once", {31'd0, IF_flush}, 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("lit_drain_ack_addr", imem_addr, 32'h10C);
        checkOutput("lit_stale_not_written", {31'd0, IF_ID_write}, 32'd0);

        // New target fetched; stall there, then redirect while in HOLD.
        nextCycle();
        latency = 0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
        @(negedge clk);
        checkOutput("lit_addr_200", imem_addr, 32'h200);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h203, 1'b1, 5'd7, 5'd7, 5'd0);
        @(negedge clk);
        checkOutput("lit_hold_redir_flush", {31'd0, IF_flush}, 32'd1);
        checkOutput("lit_hold_redir_bubble", {31'd0, ID_EX_bubble}, 32'd0);
        checkOutput("lit_hold_redir_write", {31'd0, IF_ID_write}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("lit_aligned_addr_200", imem_addr, 32'h200);
        checkOutput("lit_fresh_inst_200", inst, 32'hA5A5_0200);

        // PC wrap-around at the top of the address space.
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("lit_ack_redirect_write", {31'd0, IF_ID_write}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("lit_addr_top", imem_addr, 32'hFFFF_FFFC);
        checkOutput("lit_pc_next_wrap", pc_next, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("lit_addr_wrapped", imem_addr, 32'h0);
        checkOutput("lit_flush_cnt_3", perf_flush_cnt, PERF_EN ? 32'd3 : 32'd0);

        // Reset while holding a buffered instruction.
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        @(negedge clk);
        checkOutput("lit_midhold_reset_write", {31'd0, IF_ID_write}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("lit_after_reset_req", {31'd0, imem_req}, 32'd1);
        checkOutput("lit_after_reset_addr", imem_addr, 32'h100);
        checkOutput("lit_after_reset_inst", inst, 32'hA5A5_0100);

        nextCycle();
        nextCycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
